// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: FU count/select codes, write-back packet, ROB age helper.
package ooo_pkg;

    localparam int unsigned NUM_FU    = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ROB_IDX_W = 3;
    localparam int unsigned FU_SEL_W  = 3;

    // FU select encodings; the value is the requester index on the write-back arbiter
    typedef enum logic [FU_SEL_W-1:0] {
        FU_ALU = 3'd0,
        FU_MUL = 3'd1,
        FU_DIV = 3'd2,
        FU_LSU = 3'd3,
        FU_BR  = 3'd4
    } fu_sel_e;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [ROB_IDX_W-1:0] rob_idx;
    } wb_pkt_t;

    // Distance of a ROB entry from the head; subtraction wraps modulo ROB depth
    function automatic logic [ROB_IDX_W-1:0] rob_age(input logic [ROB_IDX_W-1:0] idx,
                                                     input logic [ROB_IDX_W-1:0] head);
        return idx - head;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N = 5,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    logic              w_found;
    int unsigned       w_sum;
    logic [W-1:0]      w_pos;

    // Scan requesters from ptr upward, wrapping modulo N; lock onto the first hit
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_sum     = 0;
        w_pos     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_sum = int'(ptr) + k;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_pos = W'(w_sum);
            if (!w_found && req[w_pos]) begin
                w_found      = 1'b1;
                grant[w_pos] = 1'b1;
                grant_idx    = w_pos;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one holding buffer per FU, round-robin grant onto the single
// registered ROB write-back port, with mispredict squash of younger results.
module wb_arbiter #(
    parameter int unsigned NUM_FU    = ooo_pkg::NUM_FU,
    parameter int unsigned DATA_W    = ooo_pkg::DATA_W,
    parameter int unsigned ROB_IDX_W = ooo_pkg::ROB_IDX_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_FU-1:0]                    fu_wb_valid,
    input  logic [NUM_FU-1:0][DATA_W-1:0]        fu_wb_data,
    input  logic [NUM_FU-1:0][ROB_IDX_W-1:0]     fu_wb_rob_idx,
    output logic [NUM_FU-1:0]                    fu_wb_ready,
    input  logic [ROB_IDX_W-1:0]                 rob_head,
    input  logic                                 mispredict,
    input  logic [ROB_IDX_W-1:0]                 mis_rob_idx,
    output logic                                 WB_valid,
    output logic [DATA_W-1:0]                    WB_data,
    output logic [ROB_IDX_W-1:0]                 WB_rob_idx,
    output logic [2:0]                           grant_fu
);

    import ooo_pkg::*;

    wb_pkt_t                r_buf [NUM_FU];
    logic [NUM_FU-1:0]      r_buf_valid;
    logic [FU_SEL_W-1:0]    r_rr_ptr;
    logic                   r_wb_valid;
    wb_pkt_t                r_wb_pkt;
    logic [FU_SEL_W-1:0]    r_grant_fu;

    logic [NUM_FU-1:0]      w_kill;
    logic [NUM_FU-1:0]      w_in_kill;
    logic [NUM_FU-1:0]      w_req;
    logic [NUM_FU-1:0]      w_grant;
    logic [FU_SEL_W-1:0]    w_grant_idx;
    logic [ROB_IDX_W-1:0]   w_mis_age;
    wb_pkt_t                w_sel_pkt;

    assign w_mis_age = rob_age(mis_rob_idx, rob_head);

    // Squash decision for both buffered and incoming results: strictly younger than the branch
    always_comb begin
        w_kill    = '0;
        w_in_kill = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            w_kill[i]    = mispredict && (rob_age(r_buf[i].rob_idx, rob_head) > w_mis_age);
            w_in_kill[i] = mispredict && (rob_age(fu_wb_rob_idx[i], rob_head) > w_mis_age);
        end
    end

    assign w_req = r_buf_valid & ~w_kill;

    rr_arbiter #(
        .N (NUM_FU),
        .W (FU_SEL_W)
    ) u_rr (
        .req       (w_req),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Ready depends only on buffer state and grant, never on fu_wb_valid
    assign fu_wb_ready = {NUM_FU{rst}} & (~r_buf_valid | w_grant);
    assign w_sel_pkt   = r_buf[w_grant_idx];

    // Per-FU holding buffers: capture replaces a granted entry; a young capture is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_valid <= '0;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (fu_wb_valid[i] && fu_wb_ready[i]) begin
                    r_buf_valid[i] <= !w_in_kill[i];
                    r_buf[i]       <= '{data: fu_wb_data[i], rob_idx: fu_wb_rob_idx[i]};
                end else if (w_grant[i] || w_kill[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer moves past the winner; holds when nothing is granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (|w_grant) begin
            r_rr_ptr <= (w_grant_idx == FU_SEL_W'(NUM_FU - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // Registered write-back port; payload zeroed on idle cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid <= 1'b0;
            r_wb_pkt   <= '0;
            r_grant_fu <= '0;
        end else begin
            r_wb_valid <= |w_grant;
            if (|w_grant) begin
                r_wb_pkt   <= w_sel_pkt;
                r_grant_fu <= w_grant_idx;
            end else begin
                r_wb_pkt   <= '0;
                r_grant_fu <= '0;
            end
        end
    end

    assign WB_valid   = r_wb_valid;
    assign WB_data    = r_wb_pkt.data;
    assign WB_rob_idx = r_wb_pkt.rob_idx;
    assign grant_fu   = r_grant_fu;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter with hand-computed expected values.
module tb_wb_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       fu_wb_valid;
    logic [4:0][31:0] fu_wb_data;
    logic [4:0][2:0]  fu_wb_rob_idx;
    logic [4:0]       fu_wb_ready;
    logic [2:0]       rob_head;
    logic             mispredict;
    logic [2:0]       mis_rob_idx;
    logic             WB_valid;
    logic [31:0]      WB_data;
    logic [2:0]       WB_rob_idx;
    logic [2:0]       grant_fu;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .NUM_FU    (5),
        .DATA_W    (32),
        .ROB_IDX_W (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fu_wb_valid   (fu_wb_valid),
        .fu_wb_data    (fu_wb_data),
        .fu_wb_rob_idx (fu_wb_rob_idx),
        .fu_wb_ready   (fu_wb_ready),
        .rob_head      (rob_head),
        .mispredict    (mispredict),
        .mis_rob_idx   (mis_rob_idx),
        .WB_valid      (WB_valid),
        .WB_data       (WB_data),
        .WB_rob_idx    (WB_rob_idx),
        .grant_fu      (grant_fu)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic [31:0] d,
                          input logic [2:0] idx, input logic [2:0] g);
        chk({tag, ".valid"}, 64'(WB_valid), 64'(v));
        chk({tag, ".data"},  64'(WB_data), 64'(d));
        chk({tag, ".idx"},   64'(WB_rob_idx), 64'(idx));
        chk({tag, ".gfu"},   64'(grant_fu), 64'(g));
    endtask

    task automatic clear_inputs();
        fu_wb_valid   = '0;
        fu_wb_data    = '0;
        fu_wb_rob_idx = '0;
        mispredict    = 1'b0;
        mis_rob_idx   = '0;
        rob_head      = '0;
    endtask

    // Leaves the bench just after a falling edge with rst released
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        #1 rst = 1'b0;
        #1;
        chk_wb("reset", 1'b0, 32'h0, 3'd0, 3'd0);
        chk("reset.ready", 64'(fu_wb_ready), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("post_reset.ready", 64'(fu_wb_ready), 64'h1f);

        // Single result: visible on WB two edges after the handshake
        @(negedge clk);
        fu_wb_valid[2] = 1'b1; fu_wb_data[2] = 32'hDEADBEEF; fu_wb_rob_idx[2] = 3'd5;
        @(negedge clk);
        fu_wb_valid = '0;
        chk_wb("t1_c1", 1'b0, 32'h0, 3'd0, 3'd0);
        @(negedge clk);
        chk_wb("t1_c2", 1'b1, 32'hDEADBEEF, 3'd5, 3'd2);
        @(negedge clk);
        chk_wb("t1_c3", 1'b0, 32'h0, 3'd0, 3'd0);

        // All five FUs at once from rr_ptr=0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fu_wb_valid[i] = 1'b1; fu_wb_data[i] = 32'h100 + 32'(i); fu_wb_rob_idx[i] = 3'(i);
        end
        @(negedge clk);
        fu_wb_valid = '0;
        #1 chk("t2.ready0", 64'(fu_wb_ready), 64'h01);
        for (int k = 0; k < 5; k++) begin
            logic [4:0] exp_rdy;
            @(negedge clk);
            exp_rdy = 5'((1 << (k + 2)) - 1);
            chk_wb($sformatf("t2_wb%0d", k), 1'b1, 32'h100 + 32'(k), 3'(k), 3'(k));
            chk($sformatf("t2.ready%0d", k + 1), 64'(fu_wb_ready), 64'(exp_rdy));
        end
        @(negedge clk);
        chk_wb("t2_idle", 1'b0, 32'h0, 3'd0, 3'd0);
        // Pointer wrapped back to 0: FU0 must beat FU4
        fu_wb_valid[0] = 1'b1; fu_wb_data[0] = 32'h200; fu_wb_rob_idx[0] = 3'd6;
        fu_wb_valid[4] = 1'b1; fu_wb_data[4] = 32'h204; fu_wb_rob_idx[4] = 3'd7;
        @(negedge clk);
        fu_wb_valid = '0;
        @(negedge clk);
        chk_wb("t2_wrap0", 1'b1, 32'h200, 3'd6, 3'd0);
        @(negedge clk);
        chk_wb("t2_wrap1", 1'b1, 32'h204, 3'd7, 3'd4);

        // Continuous single requester: 1 result per cycle, ready held high
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c > 0) @(negedge clk);
            if (c >= 2 && c < 12)
                chk_wb($sformatf("t3_c%0d", c), 1'b1, 32'hA000 + 32'(c - 2), 3'(c - 2), 3'd1);
            else
                chk_wb($sformatf("t3_c%0d", c), 1'b0, 32'h0, 3'd0, 3'd0);
            if (c < 10) begin
                fu_wb_valid[1] = 1'b1; fu_wb_data[1] = 32'hA000 + 32'(c); fu_wb_rob_idx[1] = 3'(c);
            end else begin
                fu_wb_valid = '0;
            end
            #1 chk($sformatf("t3.ready1_c%0d", c), 64'(fu_wb_ready[1]), 64'h1);
        end

        // Mispredict with head wrap: idx 1 (age 3) is younger than idx 0 (age 2)
        do_reset();
        rob_head = 3'd6;
        fu_wb_valid[0] = 1'b1; fu_wb_data[0] = 32'h40; fu_wb_rob_idx[0] = 3'd7;
        fu_wb_valid[1] = 1'b1; fu_wb_data[1] = 32'h41; fu_wb_rob_idx[1] = 3'd0;
        fu_wb_valid[3] = 1'b1; fu_wb_data[3] = 32'h43; fu_wb_rob_idx[3] = 3'd1;
        @(negedge clk);
        fu_wb_valid = '0; mispredict = 1'b1; mis_rob_idx = 3'd0;
        #1 chk("t4.ready", 64'(fu_wb_ready), 64'h15);
        @(negedge clk);
        mispredict = 1'b0;
        chk_wb("t4_wb0", 1'b1, 32'h40, 3'd7, 3'd0);
        @(negedge clk);
        chk_wb("t4_wb1", 1'b1, 32'h41, 3'd0, 3'd1);
        @(negedge clk);
        chk_wb("t4_idle0", 1'b0, 32'h0, 3'd0, 3'd0);
        chk("t4.ready_end", 64'(fu_wb_ready), 64'h1f);
        @(negedge clk);
        chk_wb("t4_idle1", 1'b0, 32'h0, 3'd0, 3'd0);

        // Incoming young result during mispredict is accepted and dropped; older one kept
        do_reset();
        rob_head = 3'd0; mispredict = 1'b1; mis_rob_idx = 3'd2;
        fu_wb_valid[4] = 1'b1; fu_wb_data[4] = 32'h55; fu_wb_rob_idx[4] = 3'd5;
        fu_wb_valid[0] = 1'b1; fu_wb_data[0] = 32'h50; fu_wb_rob_idx[0] = 3'd1;
        #1 chk("t5.ready4", 64'(fu_wb_ready[4]), 64'h1);
        @(negedge clk);
        fu_wb_valid = '0; mispredict = 1'b0;
        #1 chk("t5.ready_next", 64'(fu_wb_ready), 64'h1f);
        @(negedge clk);
        chk_wb("t5_wb0", 1'b1, 32'h50, 3'd1, 3'd0);
        @(negedge clk);
        chk_wb("t5_idle0", 1'b0, 32'h0, 3'd0, 3'd0);
        @(negedge clk);
        chk_wb("t5_idle1", 1'b0, 32'h0, 3'd0, 3'd0);

        // Asynchronous reset mid-cycle with results pending
        do_reset();
        fu_wb_valid[0] = 1'b1; fu_wb_data[0] = 32'h60; fu_wb_rob_idx[0] = 3'd1;
        fu_wb_valid[2] = 1'b1; fu_wb_data[2] = 32'h62; fu_wb_rob_idx[2] = 3'd2;
        fu_wb_valid[4] = 1'b1; fu_wb_data[4] = 32'h64; fu_wb_rob_idx[4] = 3'd3;
        @(negedge clk);
        fu_wb_valid = '0;
        @(negedge clk);
        chk_wb("t6_pre", 1'b1, 32'h60, 3'd1, 3'd0);
        #2 rst = 1'b0;
        #1;
        chk_wb("t6_rst", 1'b0, 32'h0, 3'd0, 3'd0);
        chk("t6.ready_rst", 64'(fu_wb_ready), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("t6.ready_rel", 64'(fu_wb_ready), 64'h1f);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_wb($sformatf("t6_idle%0d", c), 1'b0, 32'h0, 3'd0, 3'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
